// File: rtl/mmu_arbiter.sv
// Two-master arbiter and access sequencer for the mmu data port.
// Grants M0/M1, checks legality, then runs issue -> wait -> respond.
module mmu_arbiter #(
    parameter int MEM_LATENCY = 1,
    parameter bit RR_ENABLE   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_we,
    input  logic        m1_we,
    input  logic [2:0]  m0_funct3,
    input  logic [2:0]  m1_funct3,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m1_wdata,
    output logic        m0_ack,
    output logic        m1_ack,
    output logic        m0_err,
    output logic        m1_err,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic        mmu_load_enable,
    output logic        mmu_store_enable,
    output logic        mmu_is_lb,
    output logic        mmu_is_lbu,
    output logic        mmu_is_lh,
    output logic        mmu_is_lhu,
    output logic        mmu_is_lw,
    output logic        mmu_is_sb,
    output logic        mmu_is_sh,
    output logic        mmu_is_sw,
    output logic [31:0] mmu_address,
    output logic [31:0] mmu_data_in,
    input  logic [31:0] mmu_data_out,
    output logic        busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

    logic [1:0]  state_q, state_d;
    logic        id_q, id_d;
    logic        last_q, last_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        sel_m1;
    logic        sel_we;
    logic [2:0]  sel_f3;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        f3_ok;
    logic        align_ok;

    // Pick the winner and judge whether its access is legal.
    always_comb begin
        sel_m1    = m1_req && (!m0_req || (RR_ENABLE && !last_q));
        sel_we    = sel_m1 ? m1_we     : m0_we;
        sel_f3    = sel_m1 ? m1_funct3 : m0_funct3;
        sel_addr  = sel_m1 ? m1_addr   : m0_addr;
        sel_wdata = sel_m1 ? m1_wdata  : m0_wdata;
        case (sel_f3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = !sel_we;
            default:                f3_ok = 1'b0;
        endcase
        case (sel_f3[1:0])
            2'b01:   align_ok = !sel_addr[0];
            2'b10:   align_ok = (sel_addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
    end

    // Sequencer next state: latch in IDLE, count in WAIT, respond once.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        last_d  = last_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    id_d    = sel_m1;
                    last_d  = sel_m1;
                    we_d    = sel_we;
                    f3_d    = sel_f3;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    rdata_d = '0;
                    cnt_d   = '0;
                    err_d   = !(f3_ok && align_ok);
                    state_d = (f3_ok && align_ok) ? S_ISSUE : S_RESP;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    if (!we_q) rdata_d = mmu_data_out;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; pointer resets so that M0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            last_q  <= last_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    logic act;
    logic ld;
    logic st;
    logic resp;

    // Decode mmu strobes and master responses from the current state.
    always_comb begin
        act  = (state_q == S_ISSUE) || (state_q == S_WAIT);
        ld   = act && !we_q;
        st   = (state_q == S_ISSUE) && we_q;
        resp = (state_q == S_RESP);
        mmu_load_enable  = ld;
        mmu_store_enable = st;
        mmu_is_lb   = ld && (f3_q == 3'b000);
        mmu_is_lh   = ld && (f3_q == 3'b001);
        mmu_is_lw   = ld && (f3_q == 3'b010);
        mmu_is_lbu  = ld && (f3_q == 3'b100);
        mmu_is_lhu  = ld && (f3_q == 3'b101);
        mmu_is_sb   = st && (f3_q == 3'b000);
        mmu_is_sh   = st && (f3_q == 3'b001);
        mmu_is_sw   = st && (f3_q == 3'b010);
        mmu_address = act ? addr_q : '0;
        mmu_data_in = (act && we_q) ? wdata_q : '0;
        m0_ack   = resp && !id_q;
        m1_ack   = resp && id_q;
        m0_err   = m0_ack && err_q;
        m1_err   = m1_ack && err_q;
        m0_rdata = m0_ack ? rdata_q : '0;
        m1_rdata = m1_ack ? rdata_q : '0;
        busy     = (state_q != S_IDLE);
    end

endmodule
